// File: rtl/serial_queue_bridge_if.sv
// Pin-side bundle for serial_queue_bridge: serial bit input, dequeue request, queue status/data.
// master drives the serial bits and pop requests; slave is the bridge itself.
interface serial_queue_bridge_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
);
  logic                       data_in;
  logic                       write_in;
  logic                       dequeue_in;
  logic                       status_out;
  logic [DATA_W-1:0]          data_out;
  logic [$clog2(DEPTH+1)-1:0] len_out;
  logic                       full_out;
  logic                       empty_out;
  logic                       overflow_out;

  modport master (
    output data_in, write_in, dequeue_in,
    input  status_out, data_out, len_out, full_out, empty_out, overflow_out
  );

  modport slave (
    input  data_in, write_in, dequeue_in,
    output status_out, data_out, len_out, full_out, empty_out, overflow_out
  );
endinterface

// File: rtl/serial_queue_bridge.sv
// Serial bit deserializer feeding a DEPTH-entry queue, paced by des/q clock-enable ticks.
// A finished word waits in HOLD until the queue accepts it; bits arriving meanwhile are dropped and flagged.
module serial_queue_bridge #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 8,
  parameter int DES_DIV = 10,
  parameter int Q_DIV   = 100
) (
  input logic              clock_1MHz,
  input logic              reset,
  serial_queue_bridge_if.slave bus
);
  localparam int LEN_W  = $clog2(DEPTH + 1);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int BIT_W  = $clog2(DATA_W + 1);
  localparam int DCNT_W = (DES_DIV > 1) ? $clog2(DES_DIV) : 1;
  localparam int QCNT_W = (Q_DIV > 1) ? $clog2(Q_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_HOLD
  } des_state_t;

  logic [DCNT_W-1:0] des_cnt;
  logic [QCNT_W-1:0] q_cnt;
  logic              des_tick;
  logic              q_tick;

  des_state_t        state;
  logic [DATA_W-1:0] sr;
  logic [BIT_W-1:0]  bitcnt;
  logic              req;
  logic              status_q;
  logic              overflow_q;
  logic              ack;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  len_next;
  logic              full_q;
  logic              empty_q;
  logic [DATA_W-1:0] data_q;
  logic              push_ok;
  logic              pop_ok;

  assign des_tick = (des_cnt == DCNT_W'(DES_DIV - 1));
  assign q_tick   = (q_cnt == QCNT_W'(Q_DIV - 1));

  always_ff @(posedge clock_1MHz or posedge reset) begin
    if (reset) begin
      des_cnt <= '0;
      q_cnt   <= '0;
    end else begin
      des_cnt <= des_tick ? '0 : des_cnt + DCNT_W'(1);
      q_cnt   <= q_tick ? '0 : q_cnt + QCNT_W'(1);
    end
  end

  // Deserializer: MSB-first shift, one bit per des_tick while write_in is high.
  always_ff @(posedge clock_1MHz or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      sr         <= '0;
      bitcnt     <= '0;
      req        <= 1'b0;
      status_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (des_tick && bus.write_in) begin
            sr       <= {sr[DATA_W-2:0], bus.data_in};
            bitcnt   <= BIT_W'(1);
            state    <= S_SHIFT;
            status_q <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (des_tick && bus.write_in) begin
            sr <= {sr[DATA_W-2:0], bus.data_in};
            if (bitcnt == BIT_W'(DATA_W - 1)) begin
              bitcnt <= BIT_W'(DATA_W);
              state  <= S_HOLD;
              req    <= 1'b1;
            end else begin
              bitcnt <= bitcnt + BIT_W'(1);
            end
          end
        end
        S_HOLD: begin
          // A tick with a valid bit here means that bit is lost, even if ack lands on the same edge.
          if (des_tick && bus.write_in) begin
            overflow_q <= 1'b1;
          end
          if (ack) begin
            state    <= S_IDLE;
            req      <= 1'b0;
            bitcnt   <= '0;
            status_q <= 1'b0;
          end
        end
        default: begin
          state    <= S_IDLE;
          req      <= 1'b0;
          bitcnt   <= '0;
          status_q <= 1'b0;
        end
      endcase
    end
  end

  // Full queue may still accept a push when a pop frees the slot on the same tick.
  assign pop_ok  = bus.dequeue_in && (len != '0);
  assign push_ok = req && ((len < LEN_W'(DEPTH)) || pop_ok);
  assign ack     = q_tick && push_ok;

  always_comb begin
    len_next = len;
    if (q_tick) begin
      case ({push_ok, pop_ok})
        2'b10:   len_next = len + LEN_W'(1);
        2'b01:   len_next = len - LEN_W'(1);
        default: len_next = len;
      endcase
    end
  end

  always_ff @(posedge clock_1MHz) begin
    if (q_tick && push_ok) begin
      mem[wr_ptr] <= sr;
    end
  end

  always_ff @(posedge clock_1MHz or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      len     <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      data_q  <= '0;
    end else begin
      len     <= len_next;
      full_q  <= (len_next == LEN_W'(DEPTH));
      empty_q <= (len_next == '0);
      if (q_tick && push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (q_tick && pop_ok) begin
        data_q <= mem[rd_ptr];
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  assign bus.status_out   = status_q;
  assign bus.data_out     = data_q;
  assign bus.len_out      = len;
  assign bus.full_out     = full_q;
  assign bus.empty_out    = empty_q;
  assign bus.overflow_out = overflow_q;
endmodule
